// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decode and issue {A, B, ctrl} to the ALU through a 2-entry skid buffer
//   in:  clk, rst_n (async, active-low), flush, in_valid, rs1_val, rs2_val, imm, opcode, funct3, funct7_5, out_ready
//   out: in_ready, out_valid, alu_a, alu_b, alu_ctrl, out_illegal, illegal_cnt
module alu_issue_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] rs1_val,
  input  logic [WIDTH-1:0] rs2_val,
  input  logic [WIDTH-1:0] imm,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  output logic             out_illegal,
  output logic [15:0]      illegal_cnt
);
  typedef struct packed {
    logic             ill;
    logic [2:0]       ctrl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } bundle_t;
  bundle_t dec, main_q, skid_q;
  logic main_v, skid_v, in_fire, out_fire, load_main, main_v_next, skid_v_next;
  logic rtype, itype;
  always_comb begin
    rtype = opcode == 7'b0110011;
    itype = opcode == 7'b0010011;
    dec.a = rs1_val;
    dec.b = rs2_val;
    dec.ctrl = 3'b000;
    dec.ill = 1'b0;
    if (opcode == 7'b0000011 || opcode == 7'b0100011) dec.b = imm;
    else if (opcode == 7'b1100011) dec.ctrl = 3'b001;
    else if (rtype || itype) begin
      dec.b = itype ? imm : rs2_val;
      case (funct3)
        3'b000:  dec.ctrl = (rtype && funct7_5) ? 3'b001 : 3'b000;
        3'b010:  dec.ctrl = 3'b101;
        3'b110:  dec.ctrl = 3'b011;
        3'b111:  dec.ctrl = 3'b010;
        default: begin
          dec.ill = 1'b1;
          dec.b = rs2_val;
        end
      endcase
    end else dec.ill = 1'b1;
  end
  // in_ready mirrors ~skid_v, so an input never arrives while the skid still holds an op
  always_comb begin
    in_fire = in_valid & in_ready;
    out_fire = main_v & out_ready;
    load_main = ~main_v | out_fire;
    main_v_next = load_main ? (skid_v | in_fire) : 1'b1;
    skid_v_next = load_main ? 1'b0 : (skid_v | in_fire);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      in_ready <= 1'b1;
      main_q <= '0;
      skid_q <= '0;
      illegal_cnt <= '0;
    end else begin
      if (out_fire && main_q.ill && illegal_cnt != 16'hFFFF) illegal_cnt <= illegal_cnt + 16'd1;
      if (flush) begin
        main_v <= 1'b0;
        skid_v <= 1'b0;
        in_ready <= 1'b1;
      end else begin
        main_v <= main_v_next;
        skid_v <= skid_v_next;
        in_ready <= ~skid_v_next;
        if (load_main && skid_v) main_q <= skid_q;
        else if (load_main && in_fire) main_q <= dec;
        if (!load_main && in_fire) skid_q <= dec;
      end
    end
  end
  assign out_valid = main_v;
  assign alu_a = main_q.a;
  assign alu_b = main_q.b;
  assign alu_ctrl = main_q.ctrl;
  assign out_illegal = main_q.ill;
endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Operand-issue stage directly upstream of the 32-bit RISC-V ALU. Decodes opcode/funct3/funct7[5] into the ALU's 3-bit control code and selects the B operand (rs2 or immediate). It presents a registered {A, B, control} bundle to the ALU through a valid/ready handshake. A 2-entry skid buffer sustains one issue per cycle under back-pressure, and a synchronous flush discards in-flight operations on redirect.

## Interface
- WIDTH, 32, operand width; the ALU consumes 32.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous; discard all held entries
- in_valid  input  1  upstream offers an op
- in_ready  output  1  stage can accept; registered
- rs1_val  input  WIDTH  source register 1 value
- rs2_val  input  WIDTH  source register 2 value
- imm  input  WIDTH  sign-extended immediate
- opcode  input  7  instruction opcode
- funct3  input  3  instruction funct3
- funct7_5  input  1  instruction bit 30
- out_valid  output  1  bundle valid toward the ALU
- out_ready  input  1  ALU/downstream consumes bundle
- alu_a  output  WIDTH  A operand (rs1_val)
- alu_b  output  WIDTH  B operand
- alu_ctrl  output  3  ALU control code
- out_illegal  output  1  op not supported by the ALU
- illegal_cnt  output  16  saturating count of illegal ops issued

## Operation
- Decode is combinational on the input and captured with the operands:
  - opcode 0000011 (load) or 0100011 (store) -> ctrl 000 (add), B=imm.
  - opcode 1100011 (branch) -> ctrl 001 (sub), B=rs2_val.
  - opcode 0110011 (R-type) -> B=rs2_val.
  - opcode 0010011 (I-type) -> B=imm.
- R/I funct3 mapping:
  - 000 -> 001 (sub) if R-type and funct7_5=1, else 000 (add).
  - 010 -> 101 (slt).
  - 110 -> 011 (or).
  - 111 -> 010 (and).
  - Any other funct3 -> illegal.
- Any other opcode -> illegal.
- Illegal ops are still issued, with ctrl 000, B=rs2_val, out_illegal=1.
- alu_a is always rs1_val.
- Storage is a main register (drives the out_* ports) plus a skid register. Occupancy is 0..2.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready next-state = ~skid_full_next.
- When main is empty or out_fire:
  - If the skid is full, main loads from the skid and the skid empties.
  - Otherwise, if in_fire, main loads from the input.
  - Otherwise, out_valid goes to 0.
- When main is full, not out_fire, and in_fire: the input is written to the skid.
- flush=1 clears both valid bits and sets in_ready=1 next cycle. A same-cycle in_fire is dropped, and a same-cycle out_fire still counts as consumed.
- illegal_cnt increments on each out_fire with out_illegal=1 (not if flushed before issue). It saturates at 16'hFFFF and is not cleared by flush.
- Ordering is strictly FIFO; no op is lost or duplicated except via flush.

## Timing
- Reset (async assert, synchronous release):
  - out_valid=0, out_illegal=0, illegal_cnt=0.
  - in_ready=1.
  - alu_a=0, alu_b=0, alu_ctrl=000.
  - Skid is empty.
- Latency: in_fire at edge N -> out_valid=1 with that bundle after edge N, visible in cycle N+1.
- Throughput: 1 op/cycle with out_ready held high; in_ready stays 1.
- Back-pressure:
  - out_ready=0 with main full: one more op is accepted into the skid.
  - in_ready falls the cycle after the skid fills.
  - The first out_fire afterwards moves skid to main; in_ready rises the following cycle.
- Out_* data is held stable while out_valid=1 and out_ready=0.
- Reset asserted mid-operation: all entries dropped immediately, outputs go to reset values.

## Test plan
- Add streaming:
  - Stimulus: opcode 0110011, funct3 000, funct7_5 0, rs1=5, rs2=7, out_ready=1, 4 back-to-back ops.
  - Response: each appears 1 cycle later with ctrl 000, a=5, b=7; in_ready stays 1; 4 out_fires in 4 cycles.
- Decode sweep:
  - Sub: R-type funct7_5=1 -> ctrl 001.
  - Slt: I-type funct3 010, imm=32'hFFFFFFFC -> ctrl 101, b=FFFFFFFC.
  - Or/and: funct3 110/111 -> ctrl 011/010.
  - Memory: load/store -> ctrl 000, b=imm.
  - Branch: beq -> ctrl 001, b=rs2.
- Back-pressure:
  - Stimulus: out_ready=0 while issuing ops X, Y, Z.
  - Response: X held in main, Y in skid, in_ready=0 from the next cycle, Z waits.
  - Release out_ready=1: outputs X, Y, Z in order, one per cycle.
- Flush:
  - Stimulus: with main+skid full, assert flush together with in_valid.
  - Response: next cycle out_valid=0, in_ready=1; the flushed ops and the same-cycle input never appear.
- Illegal:
  - Stimulus: opcode 1101111 and R-type funct3 001.
  - Response: out_illegal=1, ctrl 000; illegal_cnt reaches 2 after both out_fires.
  - Saturation: force 65,537 illegal issues -> count holds FFFF.
- Reset:
  - Stimulus: assert rst_n=0 asynchronously between edges with 2 ops held.
  - Response: out_valid drops immediately, illegal_cnt=0, in_ready=1 after release.
